// File: rtl/cci_mpf_line_order_filter_if.sv
// Request/response bundle for the MPF line order filter.
// Master drives requests and releases; slave is the filter.
interface cci_mpf_line_order_filter_if #(
  parameter int ADDR_WIDTH  = 58,
  parameter int N_HASH_BITS = 9
);
  logic                   c0_in_valid;
  logic [ADDR_WIDTH-1:0]  c0_in_addr;
  logic                   c0_in_check;
  logic                   c0_in_ready;
  logic                   c0_out_valid;
  logic [N_HASH_BITS-1:0] c0_out_hash;
  logic                   c0_out_ready;

  logic                   c1_in_valid;
  logic [ADDR_WIDTH-1:0]  c1_in_addr;
  logic                   c1_in_check;
  logic                   c1_in_ready;
  logic                   c1_out_valid;
  logic [N_HASH_BITS-1:0] c1_out_hash;
  logic                   c1_out_ready;

  logic                   rd_done_valid;
  logic [N_HASH_BITS-1:0] rd_done_hash;
  logic                   wr_done_valid;
  logic [N_HASH_BITS-1:0] wr_done_hash;

  logic                   init_done;
  logic                   err;

  modport master (
    output c0_in_valid, c0_in_addr, c0_in_check, c0_out_ready,
    output c1_in_valid, c1_in_addr, c1_in_check, c1_out_ready,
    output rd_done_valid, rd_done_hash,
    output wr_done_valid, wr_done_hash,
    input  c0_in_ready, c0_out_valid, c0_out_hash,
    input  c1_in_ready, c1_out_valid, c1_out_hash,
    input  init_done, err
  );

  modport slave (
    input  c0_in_valid, c0_in_addr, c0_in_check, c0_out_ready,
    input  c1_in_valid, c1_in_addr, c1_in_check, c1_out_ready,
    input  rd_done_valid, rd_done_hash,
    input  wr_done_valid, wr_done_hash,
    output c0_in_ready, c0_out_valid, c0_out_hash,
    output c1_in_ready, c1_out_valid, c1_out_hash,
    output init_done, err
  );
endinterface

// File: rtl/cci_mpf_line_order_filter.sv
// Per-line load/store and store/store ordering filter.
// Counts in-flight reads and a busy bit for writes per line hash.
module cci_mpf_line_order_filter #(
  parameter int ADDR_WIDTH    = 58,
  parameter int N_HASH_BITS   = 9,
  parameter int N_RD_CNT_BITS = 4
) (
  input logic clk,
  input logic reset,
  cci_mpf_line_order_filter_if.slave bus
);

  localparam int NENT   = 1 << N_HASH_BITS;
  localparam int NCHUNK = (ADDR_WIDTH + N_HASH_BITS - 1) / N_HASH_BITS;
  localparam logic [N_RD_CNT_BITS-1:0] CNT_ONE = 1;
  localparam logic [N_HASH_BITS-1:0]   IDX_ONE = 1;

  typedef logic [N_HASH_BITS-1:0] hash_t;
  typedef logic [N_RD_CNT_BITS-1:0] cnt_t;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  // XOR-fold of the line address; the top chunk is zero-padded
  function automatic hash_t hashOf(input logic [ADDR_WIDTH-1:0] a);
    logic [NCHUNK*N_HASH_BITS-1:0] p;
    hash_t h;
    p = '0;
    p[ADDR_WIDTH-1:0] = a;
    h = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      h = h ^ p[i*N_HASH_BITS +: N_HASH_BITS];
    end
    return h;
  endfunction

  state_t state;
  hash_t  idx;
  logic   initDone;
  logic   errFlag;

  cnt_t            rdCnt [NENT];
  logic [NENT-1:0] wrBusy;

  hash_t c0Hash;
  hash_t c1Hash;
  hash_t rdHash;
  hash_t wrHash;

  logic run;
  logic c0Free;
  logic c1Free;
  logic c0Admit;
  logic c1Admit;
  logic c0Ready;
  logic c1Ready;
  logic c0Fire;
  logic c1Fire;
  logic rdInc;
  logic wrSet;
  logic rdDec;
  logic rdUnder;
  logic wrClr;
  logic wrUnder;
  logic sameRd;
  logic rdConflict;

  logic  c0OutValid;
  logic  c1OutValid;
  hash_t c0OutHash;
  hash_t c1OutHash;

  assign c0Hash = hashOf(bus.c0_in_addr);
  assign c1Hash = hashOf(bus.c1_in_addr);
  assign rdHash = bus.rd_done_hash;
  assign wrHash = bus.wr_done_hash;

  assign run    = (state == RUN);
  assign c0Free = !c0OutValid || bus.c0_out_ready;
  assign c1Free = !c1OutValid || bus.c1_out_ready;

  assign c0Admit = !bus.c0_in_check ||
                   (!wrBusy[c0Hash] && rdCnt[c0Hash] != '1);
  assign c0Ready = run && c0Free && c0Admit;
  assign c0Fire  = bus.c0_in_valid && c0Ready;
  assign rdInc   = c0Fire && bus.c0_in_check;

  // A checked read accepted to the same line this cycle beats the write
  assign rdConflict = rdInc && (c0Hash == c1Hash);
  assign c1Admit = !bus.c1_in_check ||
                   (!wrBusy[c1Hash] && rdCnt[c1Hash] == '0 &&
                    !rdConflict);
  assign c1Ready = run && c1Free && c1Admit;
  assign c1Fire  = bus.c1_in_valid && c1Ready;
  assign wrSet   = c1Fire && bus.c1_in_check;

  assign rdUnder = run && bus.rd_done_valid && rdCnt[rdHash] == '0;
  assign rdDec   = run && bus.rd_done_valid && !rdUnder;
  assign wrUnder = run && bus.wr_done_valid && !wrBusy[wrHash];
  assign wrClr   = run && bus.wr_done_valid && wrBusy[wrHash];
  assign sameRd  = rdInc && rdDec && (c0Hash == rdHash);

  assign bus.c0_in_ready  = c0Ready;
  assign bus.c1_in_ready  = c1Ready;
  assign bus.c0_out_valid = c0OutValid;
  assign bus.c1_out_valid = c1OutValid;
  assign bus.c0_out_hash  = c0OutHash;
  assign bus.c1_out_hash  = c1OutHash;
  assign bus.init_done    = initDone;
  assign bus.err          = errFlag;

  // Sequencer: sweep the table once after reset, then run
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      idx      <= '0;
      initDone <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          idx <= idx + IDX_ONE;
          if (idx == '1) begin
            state    <= RUN;
            initDone <= 1'b1;
          end
        end
        RUN: begin
          initDone <= 1'b1;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Table: clear during the sweep, then track admissions/releases
  always_ff @(posedge clk) begin
    if (!run) begin
      rdCnt[idx]  <= '0;
      wrBusy[idx] <= 1'b0;
    end else begin
      if (rdInc && !sameRd) begin
        rdCnt[c0Hash] <= rdCnt[c0Hash] + CNT_ONE;
      end
      if (rdDec && !sameRd) begin
        rdCnt[rdHash] <= rdCnt[rdHash] - CNT_ONE;
      end
      if (wrSet) begin
        wrBusy[c1Hash] <= 1'b1;
      end
      if (wrClr) begin
        wrBusy[wrHash] <= 1'b0;
      end
    end
  end

  // Sticky flag for releases that find nothing in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      errFlag <= 1'b0;
    end else if (rdUnder || wrUnder) begin
      errFlag <= 1'b1;
    end
  end

  // Read output stage: holds while stalled downstream
  always_ff @(posedge clk) begin
    if (reset) begin
      c0OutValid <= 1'b0;
      c0OutHash  <= '0;
    end else begin
      if (c0Free) begin
        c0OutValid <= c0Fire;
      end
      if (c0Fire) begin
        c0OutHash <= c0Hash;
      end
    end
  end

  // Write output stage: holds while stalled downstream
  always_ff @(posedge clk) begin
    if (reset) begin
      c1OutValid <= 1'b0;
      c1OutHash  <= '0;
    end else begin
      if (c1Free) begin
        c1OutValid <= c1Fire;
      end
      if (c1Fire) begin
        c1OutHash <= c1Hash;
      end
    end
  end

endmodule

// File: tb/tb_cci_mpf_line_order_filter.sv
// Bench for the line order filter: directed traffic with a
// scoreboard of expected emitted hashes per channel.
module tb_cci_mpf_line_order_filter;

  localparam int AW = 58;
  localparam int HB = 4;
  localparam int CB = 2;

  typedef struct {
    int             cy;
    logic [HB-1:0]  h;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0;
  exp_t m1;

  cci_mpf_line_order_filter_if #(
    .ADDR_WIDTH(AW),
    .N_HASH_BITS(HB)
  ) bus ();

  cci_mpf_line_order_filter #(
    .ADDR_WIDTH(AW),
    .N_HASH_BITS(HB),
    .N_RD_CNT_BITS(CB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Bit i of the address lands on hash bit i mod HB
  function automatic logic [HB-1:0] hashOf(input logic [AW-1:0] a);
    logic [HB-1:0] h;
    h = '0;
    for (int i = 0; i < AW; i++) h[i % HB] = h[i % HB] ^ a[i];
    return h;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.c0_out_valid && bus.c0_out_ready) begin
      if (q0.size() == 0) chk("c0_unexpected", 64'(1), 64'(0));
      else begin
        m0 = q0.pop_front();
        chk("c0_hash", 64'(bus.c0_out_hash), 64'(m0.h));
        chk("c0_latency", 64'(cyc), 64'(m0.cy));
      end
    end
    if (bus.c1_out_valid && bus.c1_out_ready) begin
      if (q1.size() == 0) chk("c1_unexpected", 64'(1), 64'(0));
      else begin
        m1 = q1.pop_front();
        chk("c1_hash", 64'(bus.c1_out_hash), 64'(m1.h));
        chk("c1_latency", 64'(cyc), 64'(m1.cy));
      end
    end
  end

  task automatic clearIn();
    bus.c0_in_valid   = 1'b0;
    bus.c1_in_valid   = 1'b0;
    bus.rd_done_valid = 1'b0;
    bus.wr_done_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic c);
    bus.c0_in_valid = 1'b1;
    bus.c0_in_addr  = a;
    bus.c0_in_check = c;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic c);
    bus.c1_in_valid = 1'b1;
    bus.c1_in_addr  = a;
    bus.c1_in_check = c;
  endtask

  task automatic rdDone(input logic [HB-1:0] h);
    bus.rd_done_valid = 1'b1;
    bus.rd_done_hash  = h;
  endtask

  task automatic wrDone(input logic [HB-1:0] h);
    bus.wr_done_valid = 1'b1;
    bus.wr_done_hash  = h;
  endtask

  // Check readiness of driven requests, queue expected outputs
  task automatic tick(input string tag, input logic e0, input logic e1);
    exp_t e;
    #1;
    if (bus.c0_in_valid) begin
      chk({tag, "_rdy0"}, 64'(bus.c0_in_ready), 64'(e0));
      if (e0) begin
        e.cy = cyc + 1;
        e.h  = hashOf(bus.c0_in_addr);
        q0.push_back(e);
      end
    end
    if (bus.c1_in_valid) begin
      chk({tag, "_rdy1"}, 64'(bus.c1_in_ready), 64'(e1));
      if (e1) begin
        e.cy = cyc + 1;
        e.h  = hashOf(bus.c1_in_addr);
        q1.push_back(e);
      end
    end
    @(negedge clk);
    clearIn();
  endtask

  task automatic waitInit(input string tag);
    int   n;
    logic sawReady;
    n = 0;
    sawReady = 1'b0;
    while (!bus.init_done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (!bus.init_done && (bus.c0_in_ready || bus.c1_in_ready))
        sawReady = 1'b1;
    end
    chk({tag, "_cycles"}, 64'(n), 64'(16));
    chk({tag, "_ready_low"}, 64'(sawReady), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    cyc = 0;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.c0_in_addr = '0;
    bus.c1_in_addr = '0;
    bus.c0_in_check = 1'b0;
    bus.c1_in_check = 1'b0;
    bus.rd_done_hash = '0;
    bus.wr_done_hash = '0;
    bus.c0_out_ready = 1'b1;
    bus.c1_out_ready = 1'b1;
    clearIn();
    repeat (3) @(negedge clk);
    chk("rst_c0_valid", 64'(bus.c0_out_valid), 64'(0));
    chk("rst_c1_valid", 64'(bus.c1_out_valid), 64'(0));
    chk("rst_c0_ready", 64'(bus.c0_in_ready), 64'(0));
    chk("rst_c1_ready", 64'(bus.c1_in_ready), 64'(0));
    chk("rst_init_done", 64'(bus.init_done), 64'(0));
    chk("rst_err", 64'(bus.err), 64'(0));
    chk("rst_c0_hash", 64'(bus.c0_out_hash), 64'(0));
    chk("rst_c1_hash", 64'(bus.c1_out_hash), 64'(0));
    reset = 1'b0;
    waitInit("init");

    // read then write to one line
    rd(58'h40, 1'b1);                 tick("t1_rd", 1, 0);
    wr(58'h40, 1'b1);                 tick("t1_w0", 0, 0);
    wr(58'h40, 1'b1);                 tick("t1_w1", 0, 0);
    wr(58'h40, 1'b1); rdDone(4'h4);   tick("t1_w2", 0, 0);
    wr(58'h40, 1'b1);                 tick("t1_w3", 0, 1);
    wrDone(4'h4);                     tick("t1_rel", 0, 0);

    // write then two reads
    wr(58'h80, 1'b1);                 tick("t2_wr", 0, 1);
    rd(58'h80, 1'b1);                 tick("t2_r0", 0, 0);
    rd(58'h80, 1'b1);                 tick("t2_r1", 0, 0);
    rd(58'h80, 1'b1); wrDone(4'h8);   tick("t2_r2", 0, 0);
    rd(58'h80, 1'b1);                 tick("t2_r3", 1, 0);
    rd(58'h80, 1'b1);                 tick("t2_r4", 1, 0);
    wr(58'h80, 1'b1); rdDone(4'h8);   tick("t2_w1", 0, 0);
    wr(58'h80, 1'b1); rdDone(4'h8);   tick("t2_w2", 0, 0);
    wr(58'h80, 1'b1);                 tick("t2_w3", 0, 1);
    wrDone(4'h8);                     tick("t2_rel", 0, 0);

    // same-cycle read and write
    rd(58'h100, 1'b1); wr(58'h100, 1'b1); tick("t3_same", 1, 0);
    rdDone(4'h1);                         tick("t3_rel0", 0, 0);
    rd(58'h100, 1'b1); wr(58'h100, 1'b0); tick("t3_nochk", 1, 1);
    rdDone(4'h1);                         tick("t3_rel1", 0, 0);
    rd(58'h40, 1'b1); wr(58'h80, 1'b1);   tick("t3_diff", 1, 1);
    rdDone(4'h4); wrDone(4'h8);           tick("t3_rel2", 0, 0);

    // read counter saturation
    rd(58'h200, 1'b1);                tick("t4_r0", 1, 0);
    rd(58'h200, 1'b1);                tick("t4_r1", 1, 0);
    rd(58'h200, 1'b1);                tick("t4_r2", 1, 0);
    rd(58'h200, 1'b1);                tick("t4_r3", 0, 0);
    rd(58'h200, 1'b1); rdDone(4'h2);  tick("t4_r4", 0, 0);
    rd(58'h200, 1'b1);                tick("t4_r5", 1, 0);
    for (int i = 0; i < 3; i++) begin
      rdDone(4'h2);                   tick("t4_rel", 0, 0);
    end
    wr(58'h200, 1'b1);                tick("t4_wr", 0, 1);
    wrDone(4'h2);                     tick("t4_wrel", 0, 0);

    // release underflow
    chk("t5_err_before", 64'(bus.err), 64'(0));
    rdDone(4'h5);                     tick("t5_under", 0, 0);
    chk("t5_err_set", 64'(bus.err), 64'(1));
    repeat (3) tick("t5_idle", 0, 0);
    chk("t5_err_sticky", 64'(bus.err), 64'(1));
    wr(58'h5, 1'b1);                  tick("t5_wr", 0, 1);
    wrDone(4'h5);                     tick("t5_wrel", 0, 0);

    // reset mid-traffic
    rd(58'h40, 1'b1);                 tick("t6_rd", 1, 0);
    rd(58'h40, 1'b1);
    wr(58'h80, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    clearIn();
    chk("t6_c0_valid", 64'(bus.c0_out_valid), 64'(0));
    chk("t6_c1_valid", 64'(bus.c1_out_valid), 64'(0));
    chk("t6_init_done", 64'(bus.init_done), 64'(0));
    chk("t6_err", 64'(bus.err), 64'(0));
    reset = 1'b0;
    waitInit("reinit");
    wr(58'h40, 1'b1);                 tick("t6_wr", 0, 1);
    wrDone(4'h4);                     tick("t6_wrel", 0, 0);

    repeat (2) tick("drain", 0, 0);
    chk("q0_empty", 64'(q0.size()), 64'(0));
    chk("q1_empty", 64'(q1.size()), 64'(0));
    chk("end_err", 64'(bus.err), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cci_mpf_line_order_filter.md
Name: cci_mpf_line_order_filter

Overview:
- Parametrised counting filter that enforces per-cache-line load/store and store/store ordering for MPF requests whose header sets checkLoadStoreOrder.
- Sits in the MPF request path between the AFU-facing interface and the physical channel.
- Reads (c0) and writes (c1) are admitted only when no conflicting request to the same line hash is in flight.
- Downstream logic returns the emitted hash on completion to release the entry.

Parameters:
- ADDR_WIDTH, 58: width of the cache-line virtual address (CCI_MPF_CL_VADDR_WIDTH).
- N_HASH_BITS, 9: hash index width; the table has 2^N_HASH_BITS entries.
- N_RD_CNT_BITS, 4: width of the per-entry outstanding-read counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- c0_in_valid  in  1  read request valid.
- c0_in_addr  in  ADDR_WIDTH  read line address.
- c0_in_check  in  1  read checkLoadStoreOrder.
- c0_in_ready  out  1  read accepted this cycle when valid&ready.
- c0_out_valid  out  1  admitted read valid.
- c0_out_hash  out  N_HASH_BITS  hash of the admitted read.
- c0_out_ready  in  1  downstream accepts the read.
- c1_in_valid, c1_in_addr, c1_in_check, c1_in_ready, c1_out_valid, c1_out_hash, c1_out_ready: write-channel equivalents, same widths.
- rd_done_valid  in  1  read completion.
- rd_done_hash  in  N_HASH_BITS  hash of the completed read.
- wr_done_valid  in  1  write completion.
- wr_done_hash  in  N_HASH_BITS  hash of the completed write.
- init_done  out  1  table initialisation complete.
- err  out  1  sticky release-underflow error.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Hash: XOR-fold of the address into N_HASH_BITS chunks; the top chunk is zero-padded.
- Table per entry: rd_cnt[N_RD_CNT_BITS] and wr_busy[1].
- FSM states INIT and RUN.
  - reset -> INIT with idx=0.
  - INIT clears one entry per cycle; after entry 2^N_HASH_BITS-1 is cleared -> RUN.
  - INIT therefore lasts exactly 2^N_HASH_BITS cycles after reset deasserts.
  - init_done=1 only in RUN.
- Reset values: c0/c1_out_valid=0, in_ready=0, init_done=0, err=0, out_hash=0.
- Reset mid-operation: output stages are dropped, in-flight state is discarded, and the FSM re-enters INIT.
- Admission uses table state as registered at the start of the cycle.
  - Read (check=1): admit iff !wr_busy[h] && rd_cnt[h] != all-ones.
  - Write (check=1): admit iff !wr_busy[h] && rd_cnt[h]==0.
  - check=0: always admitted; the table is not updated and no release is expected.
- Output stage: one register per channel.
  - stage_free = !out_valid || out_ready.
  - in_ready = RUN && stage_free && admit (combinational).
  - Latency is 1 cycle from acceptance to out_valid.
  - out_valid/out_hash hold stable while out_valid && !out_ready.
- Table update on acceptance: read -> rd_cnt[h]+1; write -> wr_busy[h]=1.
- Same-cycle read and write, same hash, both check=1: the read wins and the write is deasserted ready that cycle.
  - Different hashes: both may be admitted.
- Releases: rd_done decrements rd_cnt; wr_done clears wr_busy.
  - A release is visible to admission the next cycle.
  - A same-cycle increment and decrement of the same rd_cnt leaves it unchanged.
  - A same-cycle wr_done and write admission cannot collide, because admission required !wr_busy.
- Errors: rd_done with rd_cnt==0, or wr_done with wr_busy==0.
  - Sets err (sticky until reset).
  - The entry is left unchanged; no wrap-around.
- Releases arriving during INIT are ignored.

Test Plan:
- Init: deassert reset, N_HASH_BITS=4 -> init_done rises after exactly 16 cycles; in_ready=0 throughout.
- Read then write, addr 0x40, both check=1 -> read out 1 cycle later; write held with c1_in_ready=0 until the cycle after rd_done_hash=hash(0x40).
- Write then two reads, addr 0x80 -> both reads blocked until wr_done; then the reads are admitted in consecutive cycles and rd_cnt reaches 2.
- Same-cycle read+write to 0x100 -> read accepted, write blocked; with check=0 on the write -> both accepted.
- Counter saturation, N_RD_CNT_BITS=2: 3 reads to one line admitted, 4th blocked; one rd_done -> 4th admitted the next cycle.
- rd_done on an idle hash -> err=1 and stays 1; reset asserted mid-traffic -> out_valid=0 next cycle and INIT restarts.
